// File: rtl/data_cache_pkg.sv
// Shared types and constants for the AP data cache controller.
// Holds the FSM state encoding and the DDR address/burst-length constants.
package data_cache_pkg;
  localparam int DEF_DEPTH   = 16;
  localparam int DDR_SHIFT   = 3;
  localparam int IDX_W       = $clog2(DEF_DEPTH);
  localparam int BURST_LEN_W = 10;
  localparam int STAT_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WB,
    RF
  } state_t;
endpackage

// File: rtl/data_cache_mem.sv
// Window storage: DEPTH x WIDTH register file, one write port, two async read ports.
// Port a serves AP hits, port b feeds write-back beats; contents are not reset.
module data_cache_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [IW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/data_cache_ctrl.sv
// AP data cache controller: single-window cache, dirty write-back then refill on a miss.
// Optional hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache_ctrl
  import data_cache_pkg::*;
#(
  parameter int DATA_CACHE_DEPTH = 16,
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH_MEM   = 16,
  parameter int DDR_ADDR_WIDTH   = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH_MEM-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      req_ready,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [ADDR_WIDTH_MEM-1:0] tag_data,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [BURST_LEN_W-1:0]    rd_burst_len,
  input  logic                      rd_burst_data_valid,
  input  logic [DATA_WIDTH-1:0]     rd_burst_data,
  output logic                      wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [BURST_LEN_W-1:0]    wr_burst_len,
  input  logic                      wr_burst_data_req,
  output logic [DATA_WIDTH-1:0]     wr_burst_data,
  input  logic                      wr_burst_finish
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]         hit_cnt,
  output logic [STAT_W-1:0]         miss_cnt
`endif
);
  localparam int IW = $clog2(DATA_CACHE_DEPTH);
  localparam logic [BURST_LEN_W-1:0] LEN      = BURST_LEN_W'(DATA_CACHE_DEPTH);
  localparam logic [IW:0]            DEPTH_C  = (IW+1)'(DATA_CACHE_DEPTH);
  localparam logic [IW-1:0]          LAST_IDX = IW'(DATA_CACHE_DEPTH - 1);

  state_t                    state;
  logic                      valid;
  logic                      dirty;
  logic                      lat_we;
  logic [ADDR_WIDTH_MEM-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic [IW:0]               store_cnt;
  logic [IW-1:0]             rd_cnt;
  logic                      hit;
  logic                      start_rf;
  logic [IW-1:0]             idx;
  logic                      mem_we;
  logic [IW-1:0]             mem_waddr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata_a;
  logic [DATA_WIDTH-1:0]     mem_rdata_b;

  // One extra bit so a window near the top of memory does not wrap its upper bound.
  assign hit = valid
            && ({1'b0, lat_addr} >= {1'b0, tag_data})
            && ({1'b0, lat_addr} <  ({1'b0, tag_data} + (ADDR_WIDTH_MEM+1)'(DATA_CACHE_DEPTH)));
  assign idx = IW'(lat_addr - tag_data);

  assign start_rf  = (state == LOOKUP && !hit && !(valid && dirty))
                  || (state == WB && wr_burst_finish);
  assign mem_we    = (state == RF) ? rd_burst_data_valid : (state == LOOKUP && hit && lat_we);
  assign mem_waddr = (state == RF) ? rd_cnt : idx;
  assign mem_wdata = (state == RF) ? rd_burst_data : lat_wdata;

  data_cache_mem #(
    .DEPTH (DATA_CACHE_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (idx),
    .rdata_a (mem_rdata_a),
    .raddr_b (store_cnt[IW-1:0]),
    .rdata_b (mem_rdata_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      valid         <= 1'b0;
      dirty         <= 1'b0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      store_cnt     <= '0;
      rd_cnt        <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      tag_data      <= '0;
      rd_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      rd_burst_len  <= '0;
      wr_burst_req  <= 1'b0;
      wr_burst_addr <= '0;
      wr_burst_len  <= '0;
      wr_burst_data <= '0;
    end else begin
      rsp_valid <= 1'b0;
      req_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            req_ready <= 1'b1;
            state     <= IDLE;
            if (lat_we) begin
              dirty <= 1'b1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= mem_rdata_a;
            end
          end else if (valid && dirty) begin
            wr_burst_req  <= 1'b1;
            wr_burst_addr <= DDR_ADDR_WIDTH'(tag_data) << DDR_SHIFT;
            wr_burst_len  <= LEN;
            store_cnt     <= '0;
            state         <= WB;
          end
        end
        WB: begin
          if (wr_burst_data_req) begin
            wr_burst_req <= 1'b0;
            if (store_cnt < DEPTH_C) begin
              wr_burst_data <= mem_rdata_b;
              store_cnt     <= store_cnt + 1'b1;
            end
          end
          if (wr_burst_finish) begin
            wr_burst_req <= 1'b0;
            dirty        <= 1'b0;
          end
        end
        RF: begin
          if (rd_burst_data_valid) begin
            rd_burst_req <= 1'b0;
            rd_cnt       <= rd_cnt + 1'b1;
            if (rd_cnt == LAST_IDX) begin
              tag_data <= lat_addr;
              valid    <= 1'b1;
              state    <= LOOKUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Window contents are being replaced, so it stops hitting until the refill completes.
      if (start_rf) begin
        rd_burst_req  <= 1'b1;
        rd_burst_addr <= DDR_ADDR_WIDTH'(lat_addr) << DDR_SHIFT;
        rd_burst_len  <= LEN;
        rd_cnt        <= '0;
        valid         <= 1'b0;
        state         <= RF;
      end
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic refill_lookup;

  // The LOOKUP that follows a refill replays an already-counted miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refill_lookup <= 1'b0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      refill_lookup <= (state == RF) && rd_burst_data_valid && (rd_cnt == LAST_IDX);
      if (state == LOOKUP && !refill_lookup) begin
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed plus randomized bench for data_cache_ctrl against a window/DDR reference model.
// Define DATA_CACHE_STATS_EN to also track the hit/miss counters.
module tb_data_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] tag_data;
  logic        rd_burst_req;
  logic [27:0] rd_burst_addr;
  logic [9:0]  rd_burst_len;
  logic        rd_burst_data_valid = 1'b0;
  logic [15:0] rd_burst_data = '0;
  logic        wr_burst_req;
  logic [27:0] wr_burst_addr;
  logic [9:0]  wr_burst_len;
  logic        wr_burst_data_req = 1'b0;
  logic [15:0] wr_burst_data;
  logic        wr_burst_finish = 1'b0;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  data_cache_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_we              (req_we),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_rdata           (rsp_rdata),
    .tag_data            (tag_data),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_finish     (wr_burst_finish)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_cnt             (hit_cnt),
    .miss_cnt            (miss_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: DDR backing store plus the single cached window.
  logic [15:0] ddr [int];
  bit          mv;
  bit          mdirty;
  int          mtag;
  logic [15:0] mwin [16];
  int          mhit;
  int          mmiss;

  function automatic logic [15:0] ddr_rd(input int a);
    if (ddr.exists(a)) return ddr[a];
    return 16'((a * 7) + 16'h03C1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv = 1'b0;
    mdirty = 1'b0;
    mtag = 0;
    mhit = 0;
    mmiss = 0;
  endtask

  // Issues one request at the current negedge and plays the DDR side until req_ready.
  task automatic do_req(input bit we, input logic [15:0] addr, input logic [15:0] wd);
    bit          hit, exp_wb, done, saw_wr, saw_rd, wr_act, wr_pend, rd_act, extra;
    int          wr_sent, rd_sent, cyc, lat, idx;
    logic [15:0] wb_q [$];
    logic [15:0] got;
    logic        got_vld;
    hit    = mv && (int'(addr) >= mtag) && (int'(addr) < mtag + 16);
    exp_wb = !hit && mv && mdirty;
    done = 0; saw_wr = 0; saw_rd = 0; wr_act = 0; wr_pend = 0; rd_act = 0; extra = 0;
    wr_sent = 0; rd_sent = 0; cyc = 0; lat = 0; got = '0; got_vld = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      rd_burst_data_valid = 1'b0;
      wr_burst_data_req = 1'b0;
      wr_burst_finish = 1'b0;
      if (req_ready) begin
        done = 1;
        lat = cyc;
        got = rsp_rdata;
        got_vld = rsp_valid;
      end else begin
        // Noise on the request port while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        if (wr_pend) begin
          wb_q.push_back(wr_burst_data);
          ddr[mtag + wb_q.size() - 1] = mwin[wb_q.size() - 1];
          wr_pend = 0;
        end
        if (!saw_wr && wr_burst_req) begin
          saw_wr = 1;
          wr_act = 1;
          chk("wb_addr", 32'(wr_burst_addr), 32'(mtag * 8));
          chk("wb_len", 32'(wr_burst_len), 32'd16);
        end
        if (wr_act) begin
          if (wr_sent < 16) begin
            if ($urandom_range(0, 2) != 0) begin
              wr_burst_data_req = 1'b1;
              wr_sent++;
              wr_pend = 1;
            end
          end else if (!wr_pend) begin
            wr_burst_finish = 1'b1;
            wr_act = 0;
          end
        end
        if (!saw_rd && rd_burst_req) begin
          saw_rd = 1;
          rd_act = 1;
          chk("rf_addr", 32'(rd_burst_addr), 32'(int'(addr) * 8));
          chk("rf_len", 32'(rd_burst_len), 32'd16);
        end
        if (rd_act && rd_sent < 16 && $urandom_range(0, 3) != 0) begin
          rd_burst_data_valid = 1'b1;
          rd_burst_data = ddr_rd(int'(addr) + rd_sent);
          rd_sent++;
        end else if (rd_act && rd_sent == 16 && !extra) begin
          rd_burst_data_valid = 1'b1;
          rd_burst_data = 16'hDEAD;
          extra = 1;
        end
      end
    end
    req_valid = 1'b0;
    rd_burst_data_valid = 1'b0;
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b0;
    chk("req_done", 32'(done), 32'd1);
    chk("wb_seen", 32'(saw_wr), 32'(exp_wb));
    chk("rf_seen", 32'(saw_rd), 32'(!hit));
    if (exp_wb) begin
      chk("wb_beats", 32'(wb_q.size()), 32'd16);
      foreach (wb_q[i]) chk($sformatf("wb_data[%0d]", i), 32'(wb_q[i]), 32'(mwin[i]));
      mdirty = 1'b0;
    end
    if (!hit) begin
      mtag = int'(addr);
      mv = 1'b1;
      for (int i = 0; i < 16; i++) mwin[i] = ddr_rd(int'(addr) + i);
      if (mmiss < 65535) mmiss++;
    end else begin
      if (mhit < 65535) mhit++;
    end
    idx = int'(addr) - mtag;
    chk("rsp_valid", 32'(got_vld), 32'(!we));
    if (we) begin
      mwin[idx] = wd;
      mdirty = 1'b1;
    end else begin
      chk("rdata", 32'(got), 32'(mwin[idx]));
    end
    if (hit) chk("hit_latency", 32'(lat), 32'd2);
    chk("tag_data", 32'(tag_data), 32'(mtag));
`ifdef DATA_CACHE_STATS_EN
    chk("hit_cnt", 32'(hit_cnt), 32'(mhit));
    chk("miss_cnt", 32'(miss_cnt), 32'(mmiss));
`endif
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_ready"}, 32'(req_ready), 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({pfx, "_tag"}, 32'(tag_data), 32'd0);
    chk({pfx, "_rd_req"}, 32'(rd_burst_req), 32'd0);
    chk({pfx, "_rd_addr"}, 32'(rd_burst_addr), 32'd0);
    chk({pfx, "_wr_req"}, 32'(wr_burst_req), 32'd0);
    chk({pfx, "_wr_addr"}, 32'(wr_burst_addr), 32'd0);
`ifdef DATA_CACHE_STATS_EN
    chk({pfx, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
    chk({pfx, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
`endif
  endtask

  initial begin
    bit seen;
    int beats, cyc;
    model_reset();
    for (int i = 0; i < 16; i++) ddr[16'h0040 + i] = 16'hA000 + 16'(i);
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Refill from 0x40, hit at the window's top word, dirty write-back, clean misses.
    do_req(1'b0, 16'h0040, 16'h0000);
    do_req(1'b0, 16'h004F, 16'h0000);
    do_req(1'b1, 16'h0042, 16'h1234);
    do_req(1'b0, 16'h0100, 16'h0000);
    do_req(1'b0, 16'h0050, 16'h0000);
    do_req(1'b0, 16'h0200, 16'h0000);

    // Reset in the middle of a refill.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0300; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0; beats = 0; cyc = 0;
    while (beats < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rd_burst_data_valid = 1'b0;
      if (rd_burst_req) seen = 1;
      if (seen) begin
        rd_burst_data_valid = 1'b1;
        rd_burst_data = ddr_rd(16'h0300 + beats);
        beats++;
      end
    end
    @(negedge clk);
    rd_burst_data_valid = 1'b0;
    chk("mid_reset_beats", 32'(beats), 32'd5);
    rst = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(1'b0, 16'h0205, 16'h0000);

    // Window at the top of the address space extends past 0xFFFF.
    do_req(1'b1, 16'hFFF8, 16'hBEEF);
    do_req(1'b0, 16'hFFFF, 16'h0000);
    do_req(1'b0, 16'hFFF8, 16'h0000);
    do_req(1'b0, 16'h0000, 16'h0000);

    for (int n = 0; n < 150; n++) begin
      logic [15:0] a;
      if ($urandom_range(0, 9) == 0) a = 16'hFFF0 + 16'($urandom_range(0, 15));
      else a = 16'($urandom_range(0, 16'h007F));
      do_req(1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
